// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO registers
// One bit per cycle in RUN, sign fix-up and HI/LO write in FIX; stalls E-stage HI/LO users while busy.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validE,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcAE,
  input  logic [WIDTH-1:0] srcBE,
  input  logic             readHiLoE,
  input  logic             writeHiE,
  input  logic             writeLoE,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stallMD
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      counter;
  logic               is_div;
  logic               neg_res;
  logic               sign_a;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] acc;

  logic               accept;
  logic               sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;

  assign accept = (state == IDLE) && validE && startE;
  assign sgn_op = ~opE[0];
  assign a_neg  = sgn_op & srcAE[WIDTH-1];
  assign b_neg  = sgn_op & srcBE[WIDTH-1];
  assign abs_a  = a_neg ? -srcAE : srcAE;
  assign abs_b  = b_neg ? -srcBE : srcBE;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each cycle.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_a} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend bits becoming quotient bits}, shifted left each cycle.
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, op_b};
  assign div_diff = div_sh[WIDTH-1:0] - op_b;
  assign div_next = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                           : {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot, rem, raw_a, fix_hi, fix_lo;
  assign prod_fix = neg_res ? -acc : acc;
  assign quot     = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];
  assign raw_a    = sign_a ? -op_a : op_a;

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (op_b == '0) begin
        fix_hi = raw_a;
        fix_lo = '1;
      end else begin
        fix_hi = sign_a  ? -rem  : rem;
        fix_lo = neg_res ? -quot : quot;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    stallMD    = 1'b0;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (counter == CW'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (busy && validE && (startE || readHiLoE || writeHiE || writeLoE))
      stallMD = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      sign_a  <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            counter <= '0;
            is_div  <= opE[1];
            neg_res <= a_neg ^ b_neg;
            sign_a  <= a_neg;
            op_a    <= abs_a;
            op_b    <= abs_b;
            acc     <= opE[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
          end else if (validE) begin
            if (writeHiE) hi <= srcAE;
            if (writeLoE) lo <= srcAE;
          end
        end
        RUN: begin
          acc     <= is_div ? div_next : mul_next;
          counter <= counter + CW'(1);
        end
        FIX: begin
          hi      <= fix_hi;
          lo      <= fix_lo;
          counter <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed and random checks of muldiv_ctrl against an arithmetic model
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        validE, startE, readHiLoE, writeHiE, writeLoE;
  logic [1:0]  opE;
  logic [31:0] srcAE, srcBE;
  logic [31:0] hi, lo;
  logic        busy, stallMD;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .validE(validE), .startE(startE), .opE(opE),
    .srcAE(srcAE), .srcBE(srcBE), .readHiLoE(readHiLoE), .writeHiE(writeHiE),
    .writeLoE(writeLoE), .hi(hi), .lo(lo), .busy(busy), .stallMD(stallMD)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    validE = 0; startE = 0; readHiLoE = 0; writeHiE = 0; writeLoE = 0; opE = 0;
  endtask

  // Returns {hi, lo} from the instruction-set definition of each operation.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, m, p;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin p = sa * sb; r = p; end
      2'd1: r = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (op == 2'd2) begin
          q = sa / sb; m = sa % sb;
          r = {m[31:0], q[31:0]};
        end else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit probe);
    int cyc;
    logic [63:0] m;
    m = model(op, a, b);
    validE = 1; startE = 1; opE = op; srcAE = a; srcBE = b;
    tick;
    idle_inputs;
    cyc = 1;
    while (busy && cyc < 100) begin
      srcAE = $urandom; srcBE = $urandom; opE = 2'($urandom);
      if (cyc == 10) check({tag, " hold"}, {hi, lo}, {exp_hi, exp_lo});
      if (probe && cyc == 5) begin
        validE = 1; #1;
        check({tag, " plain_nostall"}, 64'(stallMD), 64'd0);
        validE = 0; readHiLoE = 1; #1;
        check({tag, " bubble_nostall"}, 64'(stallMD), 64'd0);
        validE = 1; readHiLoE = 0; writeLoE = 1; #1;
        check({tag, " mtlo_stall"}, 64'(stallMD), 64'd1);
        idle_inputs;
      end
      tick;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'd34);
    exp_hi = m[63:32];
    exp_lo = m[31:0];
    check({tag, " hilo"}, {hi, lo}, m);
  endtask

  initial begin
    int n;
    logic [31:0] r;
    logic [1:0]  op;
    logic [31:0] a, b;

    idle_inputs;
    srcAE = 32'h1234_5678; srcBE = 0;
    reset = 1;
    validE = 1; startE = 1;
    #12;
    check("reset_state", {hi, lo, 30'd0, busy, stallMD}, 96'd0);
    @(negedge clk);
    reset = 0;
    idle_inputs;
    tick;

    run_op("mult_neg", 2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_op("multu",    2'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
    run_op("div_neg",  2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("div_ovf",  2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_z",   2'd3, 32'd7, 32'd0, 1'b0);
    run_op("div_z",    2'd2, 32'hFFFF_FFF9, 32'd0, 1'b0);

    r = $urandom;
    validE = 1; writeHiE = 1; srcAE = r;
    tick;
    exp_hi = r;
    check("mthi", {32'd0, hi}, {32'd0, exp_hi});
    idle_inputs; writeLoE = 1; srcAE = ~r;
    tick;
    check("mtlo_bubble", {32'd0, lo}, {32'd0, exp_lo});
    validE = 1;
    tick;
    exp_lo = ~r;
    check("mtlo", {32'd0, lo}, {32'd0, exp_lo});
    idle_inputs;

    validE = 1; startE = 1; opE = 2'd0; srcAE = 32'hFFFF_FFFE; srcBE = 32'd3;
    tick;
    startE = 0; readHiLoE = 1; srcAE = $urandom;
    #1;
    n = 0;
    while (stallMD === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #2;
    end
    check("mfhi_stall_cycles", 64'(n), 64'd33);
    check("mfhi_sees_new", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    exp_hi = hi === 32'hFFFF_FFFF ? 32'hFFFF_FFFF : 32'hFFFF_FFFF;
    exp_lo = 32'hFFFF_FFFA;
    idle_inputs;
    tick;

    validE = 1; startE = 1; opE = 2'd0; srcAE = 32'd9; srcBE = 32'd11;
    tick;
    idle_inputs;
    repeat (9) tick;
    #2;
    reset = 1;
    validE = 1; readHiLoE = 1;
    #1;
    check("reset_midrun", {hi, lo, 30'd0, busy, stallMD}, 96'd0);
    @(posedge clk);
    #1;
    reset = 0;
    idle_inputs;
    exp_hi = 0; exp_lo = 0;
    tick;
    run_op("mult_after_rst", 2'd0, 32'd5, 32'd6, 1'b0);

    for (int i = 0; i < 14; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (i % 5 == 0) b = 0;
      else if (i % 3 == 0) b = $urandom_range(1, 9) * ((i % 2 == 0) ? 1 : -1);
      run_op("random", op, a, b, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
